cache_refill_ctrl: RTL and testbench

//   Line-refill sequencer between the set/way cache and an AXI4 read-only master port.
//   - On a cache miss it issues one INCR burst covering the missing line.
//   - It streams the returned beats into the cache's refill interface (mem_* signals).
//   - It owns the beat counter and mem_last generation, and flags bus errors.

---
 rtl/cache_refill_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Line-refill sequencer between a set/way cache and an AXI4 read-only master
//   port. On a miss it issues one INCR burst covering the whole line. It then
//   forwards each returned beat to the cache refill interface (mem_*), drives
//   mem_last on the final beat, and keeps a sticky bus error flag.
//
//   Optional feature macro: RLAST_CHECK_EN
//     defined   : m_axi_rlast is cross-checked against the beat counter. An
//                 early rlast ends the refill with mem_last and err set. A
//                 missing rlast on the counted last beat sets err.
//     undefined : m_axi_rlast is ignored and the burst end comes from the
//                 beat counter alone.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   miss, cpu_addr    miss request and its address; both held by the cache
//   m_axi_ar*         AXI read address channel (a single burst per miss)
//   m_axi_r*          AXI read data channel
//   mem_addr          byte address of the forwarded beat
//   mem_data_in       data of the forwarded beat
//   mem_wstb          byte strobes of the forwarded beat
//   mem_data_valid    one-cycle strobe per forwarded beat
//   mem_last          marks the final forwarded beat
//   busy              high whenever the FSM is not IDLE
//   err               sticky error flag for the current or most recent refill
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_SIZE_BITS = 7,
   parameter int ID_WIDTH       = 4,
   parameter int AXI_ID         = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    miss,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_data_in,
   output logic [DATA_WIDTH/8-1:0] mem_wstb,
   output logic                    mem_data_valid,
   output logic                    mem_last,
   output logic                    busy,
   output logic                    err
);

   localparam int BPW       = DATA_WIDTH / 8;
   localparam int SIZE_LOG2 = $clog2(BPW);
   localparam int BEATS     = (2 ** LINE_SIZE_BITS) / BPW;

   typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_t;

   state_t                    state_reg, state_next;
   logic [ADDR_WIDTH-1:0]     base_reg;
   logic [LINE_SIZE_BITS-1:0] beat_cnt_reg;
   logic                      err_reg;
   logic [ADDR_WIDTH-1:0]     mem_addr_reg;
   logic [DATA_WIDTH-1:0]     mem_data_reg;
   logic [BPW-1:0]            mem_wstb_reg;
   logic                      mem_valid_reg;
   logic                      mem_last_reg;

   logic beat;       // an R-channel handshake happens this cycle
   logic cnt_last;   // the counter points at the final beat of the line
   logic beat_last;  // this beat ends the refill
   logic beat_err;   // this beat carries an error

   // Constant burst description; only the base address is registered.
   assign m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign m_axi_arlen   = 8'(BEATS - 1);
   assign m_axi_arsize  = 3'(SIZE_LOG2);
   assign m_axi_arburst = 2'b01;
   assign m_axi_araddr  = base_reg;

   assign beat     = (state_reg == R) && m_axi_rvalid;
   assign cnt_last = (beat_cnt_reg == LINE_SIZE_BITS'(BEATS - 1));

`ifdef RLAST_CHECK_EN
   // Any disagreement between rlast and the counter is an error. Either source
   // of "last" ends the refill so the FSM never waits for beats that will not come.
   assign beat_last = cnt_last || m_axi_rlast;
   assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rlast != cnt_last);
`else
   logic unused_rlast;
   assign unused_rlast = m_axi_rlast;
   assign beat_last    = cnt_last;
   assign beat_err     = (m_axi_rresp != 2'b00);
`endif

   // The low address bits are replaced by the line alignment.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[LINE_SIZE_BITS-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_next    = state_reg;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      busy          = 1'b1;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (miss) state_next = AR;
         end
         AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_next = R;
         end
         R: begin
            m_axi_rready = 1'b1;
            if (beat && beat_last) state_next = DRAIN;
         end
         DRAIN: begin
            // Wait for the cache to drop miss so a stale miss cannot start another refill.
            if (!miss) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: base latch, beat counter, forwarded beat and error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         base_reg      <= '0;
         beat_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         mem_addr_reg  <= '0;
         mem_data_reg  <= '0;
         mem_wstb_reg  <= '0;
         mem_valid_reg <= 1'b0;
         mem_last_reg  <= 1'b0;
      end else begin
         mem_valid_reg <= beat;
         mem_last_reg  <= beat && beat_last;
         mem_wstb_reg  <= {BPW{beat}};
         if (state_reg == IDLE && miss) begin
            base_reg     <= {cpu_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
         end
         if (beat) begin
            mem_data_reg <= m_axi_rdata;
            mem_addr_reg <= base_reg + (ADDR_WIDTH'(beat_cnt_reg) << SIZE_LOG2);
            // Hold at the last index rather than wrapping.
            if (!cnt_last) beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_err) err_reg <= 1'b1;
         end
      end
   end

   assign mem_addr       = mem_addr_reg;
   assign mem_data_in    = mem_data_reg;
   assign mem_wstb       = mem_wstb_reg;
   assign mem_data_valid = mem_valid_reg;
   assign mem_last       = mem_last_reg;
   assign err            = err_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Directed bench for cache_refill_ctrl using the default parameters (32-bit
//   data, 128-byte lines, 32 beats). A negedge monitor checks every forwarded
//   beat against the expected address, data, strobes, last flag and err.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        miss = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [3:0]  m_axi_arid;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready = 1'b0;
   logic [31:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = '0;
   logic        m_axi_rlast = 1'b0;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [3:0]  mem_wstb;
   logic        mem_data_valid;
   logic        mem_last;
   logic        busy;
   logic        err;

   cache_refill_ctrl dut (
      .clk(clk), .reset(reset), .miss(miss), .cpu_addr(cpu_addr),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
      .mem_data_valid(mem_data_valid), .mem_last(mem_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Monitor state, set up by the driver before each refill
   bit          mon_en = 0;
   int          mon_idx = 0;
   int          exp_last = 31;
   int          exp_err_beat = -1;   // first beat index at which err must read 1
   logic [31:0] exp_base = '0;

   always @(negedge clk) begin
      if (mon_en && mem_data_valid) begin
         check("beat_addr", mem_addr, exp_base + 32'(mon_idx * 4));
         check("beat_data", mem_data_in, 32'(mon_idx));
         check("beat_wstb", mem_wstb, 4'hF);
         check("beat_last", mem_last, mon_idx == exp_last);
         check("beat_err", err, exp_err_beat >= 0 && mon_idx >= exp_err_beat);
         $display("beat %0d addr=0x%08h data=0x%0h last=%0b err=%0b",
                  mon_idx, mem_addr, mem_data_in, mem_last, err);
         mon_idx++;
      end
   end

   // One refill: ar_delay cycles of arready=0, optional 1010 rvalid gaps, an
   // rresp error on err_beat, rlast on rlast_beat (and on beat 31), and an
   // optional reset after stop_after beats.
   task automatic refill(input logic [31:0] addr, input int ar_delay, input bit gaps,
                         input int err_beat, input int rlast_beat, input int stop_after);
      int cyc, b, exp_count;
      bit valid;
      bit early_rlast;
      early_rlast = 0;
`ifdef RLAST_CHECK_EN
      early_rlast = (rlast_beat >= 0 && rlast_beat < 31);
`endif
      exp_last     = early_rlast ? rlast_beat : 31;
      exp_err_beat = err_beat;
      if (early_rlast && (exp_err_beat < 0 || rlast_beat < exp_err_beat))
         exp_err_beat = rlast_beat;
      exp_count    = (stop_after >= 0) ? stop_after : exp_last + 1;
      exp_base     = addr & 32'hFFFF_FF80;
      mon_idx      = 0;
      mon_en       = 1;

      @(posedge clk); #1;
      miss = 1'b1;
      cpu_addr = addr;
      cyc = 0;
      @(negedge clk);
      while (!m_axi_arvalid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("ar_seen", m_axi_arvalid, 1'b1);
      check("ar_err_clear", err, 1'b0);
      for (int i = 0; i < ar_delay; i++) begin
         check("ar_hold_valid", m_axi_arvalid, 1'b1);
         check("ar_hold_addr", m_axi_araddr, exp_base);
         @(negedge clk);
      end
      check("araddr", m_axi_araddr, exp_base);
      check("ar_fields", {m_axi_arid, m_axi_arlen, 1'b0, m_axi_arsize, m_axi_arburst},
            {4'd0, 8'd31, 1'b0, 3'd2, 2'd1});
      m_axi_arready = 1'b1;
      @(posedge clk); #1;
      m_axi_arready = 1'b0;

      b = 0;
      cyc = 0;
      while (b < 32 && cyc < 200 && m_axi_rready) begin
         valid = gaps ? (cyc % 2 == 0) : 1'b1;
         m_axi_rvalid = valid;
         m_axi_rdata  = 32'(b);
         m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast  = (b == rlast_beat) || (b == 31);
         @(posedge clk); #1;
         if (valid) b++;
         cyc++;
         if (stop_after >= 0 && b == stop_after) break;
      end

      if (stop_after >= 0) begin
         // Reset while the slave is still offering the next beat.
         reset = 1'b1;
         @(negedge clk);
         @(negedge clk);
         check("rst_mid_valid", mem_data_valid, 1'b0);
         check("rst_mid_busy", busy, 1'b0);
         check("rst_mid_rready", m_axi_rready, 1'b0);
         @(posedge clk); #1;
         reset = 1'b0;
         m_axi_rvalid = 1'b0;
         miss = 1'b0;
      end else begin
         // mem_last is visible now; the cache drops miss in this cycle.
         m_axi_rvalid = 1'b0;
         m_axi_rlast  = 1'b0;
         miss = 1'b0;
         @(negedge clk);
         check("drain_busy", busy, 1'b1);
         check("final_err", err, exp_err_beat >= 0);
         @(negedge clk);
         check("idle_busy", busy, 1'b0);
      end
      check("beat_count", 32'(mon_idx), 32'(exp_count));
      mon_en = 0;
      $display("refill addr=0x%08h beats=%0d err=%0b", addr, mon_idx, err);
   endtask

   initial begin
      // T1: reset held 3 cycles with miss asserted
      reset = 1'b1;
      miss  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_arvalid", m_axi_arvalid, 1'b0);
         check("rst_valid", mem_data_valid, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_err", err, 1'b0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      miss  = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      refill(32'h0000_1234, 0, 1'b0, -1, -1, -1);   // T2 clean refill
      refill(32'h0000_ABCD, 5, 1'b1, -1, -1, -1);   // T3 backpressure and gaps
      refill(32'h2000_0F80, 0, 1'b0, 7, -1, -1);    // T4 slave error on beat 7
      refill(32'h3456_7890, 0, 1'b0, -1, -1, 11);   // T5 reset after beat 10
      refill(32'h0000_0040, 1, 1'b0, -1, -1, -1);   // fresh refill after reset
      refill(32'h5000_0000, 2, 1'b0, -1, 15, -1);   // T6 rlast on beat 15

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
